// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory master.
package lsu_pkg;

  // Default number of addressable entries; the aligned byte address indexes it.
  localparam int MEM_DEPTH_DEFAULT = 1024;

  // Access size encodings on req_size (2'b11 is rejected as an error).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ERR,
    READ,
    WAIT,
    WRITE,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering: load extraction/extension, store-lane
// merge into a fetched word, and alignment checking for a given access size.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_out,
  output logic [31:0] merge_out,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_in[{addr_lo, 3'b000} +: 8];
  assign half_lane = word_in[{addr_lo[1], 4'b0000} +: 16];

  // Select, extend and merge the lane addressed by addr_lo for this size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    load_out   = '0;
    merge_out  = word_in;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        load_out = {{24{is_signed & byte_lane[7]}}, byte_lane};
        merge_out[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_out   = {{16{is_signed & half_lane[15]}}, half_lane};
        merge_out[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        load_out   = word_in;
        merge_out  = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-write-only data memory. One request at a
// time; sub-word stores are done as read-modify-write, loads are extended.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  // Highest aligned address whose full word lies inside the memory.
  localparam logic [31:0] MAX_ADDR = 32'(MEM_DEPTH - 4);

  lsu_state_e state_q, state_d;

  // Request fields kept for the duration of a transaction.
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_addr_lo;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        req_err;
  logic        word_store;
  logic [31:0] req_aligned;

  // The lane aligner checks the live request while idle and works on the
  // latched request once busy, so one instance serves both.
  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic        al_signed;
  logic [31:0] load_out;
  logic [31:0] merge_out;
  logic        misaligned;

  assign al_size    = (state_q == IDLE) ? req_size       : lat_size;
  assign al_addr_lo = (state_q == IDLE) ? req_addr[1:0]  : lat_addr_lo;
  assign al_signed  = (state_q == IDLE) ? req_signed     : lat_signed;

  lsu_lane_align u_lane_align (
    .size       (al_size),
    .addr_lo    (al_addr_lo),
    .is_signed  (al_signed),
    .word_in    (mem_rdata),
    .wdata      (lat_wdata),
    .load_out   (load_out),
    .merge_out  (merge_out),
    .misaligned (misaligned)
  );

  assign accept      = (state_q == IDLE) && req_valid;
  assign req_aligned = {req_addr[31:2], 2'b00};
  assign req_err     = (req_size == 2'b11) || misaligned || (req_aligned > MAX_ADDR);
  assign word_store  = req_write && (req_size == SIZE_WORD);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing and Moore strobe decode from the state register.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)         state_d = ERR;
          else if (word_store) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      READ: begin
        mem_read = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        state_d = lat_write ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, memory address/write buffer and load result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write   <= 1'b0;
      lat_size    <= 2'b00;
      lat_signed  <= 1'b0;
      lat_addr_lo <= 2'b00;
      lat_wdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resp_rdata  <= '0;
    end else begin
      if (accept) begin
        lat_write   <= req_write;
        lat_size    <= req_size;
        lat_signed  <= req_signed;
        lat_addr_lo <= req_addr[1:0];
        lat_wdata   <= req_wdata;
        // Stores and errors respond with zero data.
        resp_rdata  <= '0;
        // Errors never touch memory, so the bus keeps its previous values.
        if (!req_err) begin
          mem_addr <= req_aligned;
          if (word_store) mem_wdata <= req_wdata;
        end
      end
      if (state_q == WAIT) begin
        if (lat_write) mem_wdata  <= merge_out;
        else           resp_rdata <= load_out;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed test-plan steps followed by
// randomized requests, checked against a word-array reference model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Memory attached to the DUT (word array, indexed by aligned address / 4).
  logic [31:0] mem [0:DEPTH/4-1];
  // Reference contents the bench expects memory to hold.
  logic [31:0] ref_mem [0:DEPTH/4-1];

  lsu_mem_master #(.MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read, word-write data memory.
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || (sz == 2'b01 && addr % 2 != 0) ||
           (sz == 2'b10 && addr % 4 != 0) || ((addr / 4) * 4 > DEPTH - 4);
  endfunction

  // Issue one request, watch the bus until the response, and compare
  // latency, strobes and data against the reference model.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          exp_err;
    logic [7:0]  wi;
    logic [31:0] word, mask, exp_rdata, exp_wdata, aligned;
    int          sh, exp_lat, lat, nrd, nwr, n;

    exp_err   = is_err(sz, addr);
    wi        = addr[9:2];
    aligned   = addr & 32'hFFFF_FFFC;
    exp_rdata = '0;
    exp_wdata = '0;
    if (!exp_err) begin
      word = ref_mem[wi];
      sh   = 8 * int'(addr[1:0]);
      mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (wr) begin
        exp_wdata = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        exp_rdata = (word >> sh) & mask;
        if (sg && sz == 2'b00 && exp_rdata[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
        if (sg && sz == 2'b01 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
      end
    end
    exp_lat = exp_err ? 1 : (wr && sz == 2'b10) ? 2 : wr ? 4 : 3;

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_at_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0;
    nrd = 0;
    nwr = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (mem_read) begin
        nrd++;
        chk("read_addr", mem_addr, aligned);
      end
      if (mem_write) begin
        nwr++;
        chk("write_addr", mem_addr, aligned);
        chk("write_data", mem_wdata, exp_wdata);
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("read_strobes", 32'(nrd), (!exp_err && !(wr && sz == 2'b10)) ? 32'd1 : 32'd0);
    chk("write_strobes", 32'(nwr), (!exp_err && wr) ? 32'd1 : 32'd0);

    if (wr && !exp_err) ref_mem[wi] = exp_wdata;
  endtask

  initial begin
    for (int i = 0; i < DEPTH / 4; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem[0] = 32'd1;  ref_mem[0] = 32'd1;
    mem[1] = 32'd3;  ref_mem[1] = 32'd3;
    mem[2] = 32'd7;  ref_mem[2] = 32'd7;
    mem[3] = 32'd11; ref_mem[3] = 32'd11;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values.
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_mem_read",   32'(mem_read),   32'd0);
    chk("rst_mem_write",  32'(mem_write),  32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr",   mem_addr,   32'd0);
    chk("rst_mem_wdata",  mem_wdata,  32'd0);

    // Sub-word store interrupted by reset while waiting for read data.
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = SIZE_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'd13;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_read_phase", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_mem_read",   32'(mem_read),   32'd0);
    chk("abort_mem_write",  32'(mem_write),  32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_write", 32'(mem_write),  32'd0);
      chk("abort_hold_resp",  32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd12, 32'd0);
    chk("abort_mem12_kept", resp_rdata, 32'd11);

    // Directed loads and stores.
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd8, 32'd0);
    chk("lw8_value", resp_rdata, 32'd7);
    do_req(1'b1, SIZE_WORD, 1'b0, 32'd16, 32'hDEAD_BEEF);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd16, 32'd0);
    chk("lw16_value", resp_rdata, 32'hDEAD_BEEF);
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'd13, 32'h0000_0080);
    chk("sb13_merged", mem_wdata, 32'h0000_800B);
    do_req(1'b0, SIZE_BYTE, 1'b1, 32'd13, 32'd0);
    chk("lb13_value", resp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, SIZE_BYTE, 1'b0, 32'd13, 32'd0);
    chk("lbu13_value", resp_rdata, 32'h0000_0080);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd12, 32'd0);
    chk("lw12_value", resp_rdata, 32'h0000_800B);
    do_req(1'b1, SIZE_HALF, 1'b0, 32'd2, 32'h0000_1234);
    chk("sh2_merged", mem_wdata, 32'h1234_0001);
    do_req(1'b0, SIZE_HALF, 1'b1, 32'd2, 32'd0);
    chk("lh2_value", resp_rdata, 32'h0000_1234);

    // Error cases: misaligned, bad size, out of range; then the boundary.
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd6,    32'd0);
    do_req(1'b1, SIZE_HALF, 1'b0, 32'd5,    32'h0000_FFFF);
    do_req(1'b0, 2'b11,     1'b0, 32'd0,    32'd0);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'd1024, 32'd0);
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'd1027, 32'h0000_00AA);
    do_req(1'b1, SIZE_BYTE, 1'b1, 32'd1023, 32'h1234_56C3);
    do_req(1'b0, SIZE_BYTE, 1'b1, 32'd1023, 32'd0);
    chk("lb1023_value", resp_rdata, 32'hFFFF_FFC3);

    // Randomized traffic, biased toward the top of memory now and then.
    for (int t = 0; t < 120; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(1016, 1031));
      else                           a = 32'($urandom_range(0, 1023));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator on the CPU side of the data-memory port. It drives Address/Write_data/MemRead/MemWrite into the data memory.
- Accepts one load/store request at a time from the MEM pipeline stage over a valid/ready handshake.
- Handles byte, halfword and word accesses. Sub-word stores use read-modify-write because the data memory is word-write only.
- Returns load data sign- or zero-extended. Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_DEPTH, 1024, number of addressable memory entries. The aligned byte address is used directly as the entry index.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present; must stay stable until accepted.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as an error.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or bad size.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_addr  out  32  word-aligned address to memory ({addr[31:2],2'b00}).
- mem_wdata  out  32  full word to memory.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  32  memory read data. Registered by memory, valid the cycle after mem_read.

Behaviour:
- Reset (async) values:
  - state=IDLE, req_ready=1.
  - resp_valid, resp_err, mem_read, mem_write = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - All latched request fields = 0.
- Reset mid-operation: strobes drop immediately, the transaction is abandoned, and no response is issued.
- Byte lanes are little-endian: addr[1:0]=0 is bits 7:0, and so on. A half at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
- Error checks, evaluated on accept:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 11;
  - aligned addr > MEM_DEPTH-4.
- FSM states: IDLE, ERR, READ, WAIT, WRITE, RESP. All strobes are Moore outputs decoded from the state register.
- IDLE:
  - req_ready=1. On req_valid the request is latched.
  - Error -> ERR.
  - Word store -> WRITE.
  - Load or sub-word store -> READ.
- ERR:
  - resp_valid=1, resp_err=1, resp_rdata=0.
  - No memory strobe. Next state IDLE.
- READ: mem_read=1, mem_addr=aligned. Next state WAIT.
- WAIT: mem_rdata is valid.
  - Load: extract lane, extend, register into resp_rdata, then RESP.
  - Store: merge req_wdata lane into mem_rdata, register into the write buffer, then WRITE.
- WRITE:
  - mem_write=1, mem_addr=aligned.
  - mem_wdata = write buffer (word store: req_wdata unchanged).
  - Next state RESP.
- RESP: resp_valid=1, resp_err=0 for one cycle. Next state IDLE.
- Latency from accept edge to resp_valid:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- Strobes:
  - mem_read and mem_write are never high together.
  - Each is asserted exactly one cycle per transaction.
  - mem_addr and mem_wdata hold their last values outside strobes.
- req_valid while busy (ready=0) is ignored; the requester holds the request.
- Back-to-back requests: a new request is accepted in the cycle after RESP/ERR.
- Extension:
  - signed byte replicates bit 7; signed half replicates bit 15.
  - unsigned zero-fills.
  - Word loads ignore req_signed.

Decomposition:
- Package lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants;
  - FSM state enum (IDLE, ERR, READ, WAIT, WRITE, RESP);
  - MEM_DEPTH default.
- One combinational sub-module, lsu_lane_align. It takes (size, addr[1:0], signed, word_in, wdata) and produces:
  - load_out: extracted and extended;
  - merge_out: word_in with the store lane replaced;
  - misaligned flag.
- The FSM, latches and strobes stay in lsu_mem_master.

Test Plan:
- Memory preloaded mem[0]=1, mem[4]=3, mem[8]=7, mem[12]=11.
- LW addr 8 -> mem_read high exactly 1 cycle with mem_addr=8; resp_valid 3 cycles after accept; resp_rdata=7, resp_err=0.
- SW addr 16 data 0xDEADBEEF -> single mem_write cycle, no mem_read; resp after 2 cycles. Then LW 16 -> 0xDEADBEEF.
- SB addr 13 data 0x80 -> read-then-write, mem_wdata=0x0000800B; resp after 4 cycles. Then LB 13 -> 0xFFFFFF80, LBU 13 -> 0x00000080, LW 12 -> 0x0000800B.
- SH addr 2 data 0x1234 -> mem[0]=0x12340001. Then LH 2 signed -> 0x00001234.
- LW addr 6, SH addr 5, size 11, and LW addr 1024:
  - each gives resp_valid with resp_err=1 one cycle after accept;
  - mem_read and mem_write stay 0;
  - resp_rdata=0.
- Sub-word store with rst asserted during WAIT:
  - mem_read and mem_write are 0 immediately, with no resp_valid.
  - req_ready=1 after reset; mem[12] is unchanged at 11.
